// File: rtl/icache_assoc_pkg.sv
// icache_assoc_pkg: shared state encoding, default geometry and common word constants for the 2-way icache
`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Disable
`define Disable 1'b0
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0
`endif
package icache_assoc_pkg;
  localparam int SET_BITS_DEF = 6;
  localparam int WORD_BITS_DEF = 2;
  localparam int TAG_BITS_DEF = 8;
  typedef enum logic {S_IDLE = 1'b0, S_REFILL = 1'b1} state_e;
endpackage

// File: rtl/icache_way.sv
// icache_way: one way's valid/tag/data arrays with combinational tag match and a whole-line write port
module icache_way
  import icache_assoc_pkg::*;
#(
  parameter int SET_BITS = SET_BITS_DEF,
  parameter int WORD_BITS = WORD_BITS_DEF,
  parameter int TAG_BITS = TAG_BITS_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [SET_BITS-1:0]               rd_idx_i,
  input  logic [TAG_BITS-1:0]               rd_tag_i,
  input  logic [WORD_BITS-1:0]              rd_off_i,
  output logic                              hit_o,
  output logic [31:0]                       word_o,
  input  logic                              clr_i,
  input  logic                              we_i,
  input  logic [SET_BITS-1:0]               wr_idx_i,
  input  logic [TAG_BITS-1:0]               wr_tag_i,
  input  logic [(1<<WORD_BITS)-1:0][31:0]   wr_line_i,
  output logic                              wr_valid_o
);
  localparam int NS = 1 << SET_BITS;
  logic [NS-1:0] valid_q;
  logic [TAG_BITS-1:0] tag_q [NS];
  logic [(1<<WORD_BITS)-1:0][31:0] data_q [NS];
  assign hit_o = valid_q[rd_idx_i] && tag_q[rd_idx_i] == rd_tag_i;
  assign word_o = data_q[rd_idx_i][rd_off_i];
  assign wr_valid_o = valid_q[wr_idx_i];
  always_ff @(posedge clk)
    if (rst || clr_i) valid_q <= '0;
    else if (we_i) valid_q[wr_idx_i] <= 1'b1;
  always_ff @(posedge clk)
    if (we_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end
endmodule

// File: rtl/icache_assoc.sv
// icache_assoc: 2-way set-associative instruction cache with LRU replacement and word-serial refill
`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Disable
`define Disable 1'b0
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0
`endif
module icache_assoc
  import icache_assoc_pkg::*;
#(
  parameter int SET_BITS = SET_BITS_DEF,
  parameter int WORD_BITS = WORD_BITS_DEF,
  parameter int TAG_BITS = TAG_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        req_i,
  input  logic [31:0] req_addr_i,
  output logic        hit_o,
  output logic [31:0] inst_o,
  output logic        busy_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i
);
  localparam int NW = 1 << WORD_BITS;
  localparam int LO = WORD_BITS + 2;
  localparam int BW = 32 - LO;
  state_e state_q, state_d;
  logic [WORD_BITS-1:0] cnt_q, cnt_d;
  logic [BW-1:0] base_q, base_d;
  logic [NW-1:0][31:0] lbuf_q, lbuf_d, line;
  logic [(1<<SET_BITS)-1:0] lru_q, lru_d;
  logic [1:0] hit_w, wv;
  logic [31:0] word [2];
  logic lookup, acc, last, fill, victim, unused_addr;
  logic [SET_BITS-1:0] ridx, widx;
  logic [TAG_BITS-1:0] rtag, wtag;
  assign ridx = req_addr_i[LO +: SET_BITS];
  assign rtag = req_addr_i[LO+SET_BITS +: TAG_BITS];
  assign widx = base_q[0 +: SET_BITS];
  assign wtag = base_q[SET_BITS +: TAG_BITS];
  assign unused_addr = ^{req_addr_i[31:LO+SET_BITS+TAG_BITS], req_addr_i[1:0]};
  assign lookup = !rst && rdy && req_i && !flush_i && state_q == S_IDLE;
  assign acc = rdy && !flush_i && state_q == S_REFILL && mem_valid_i;
  assign last = cnt_q == WORD_BITS'(NW-1);
  assign fill = !rst && acc && last;
  assign victim = !wv[0] ? 1'b0 : !wv[1] ? 1'b1 : lru_q[widx];
  always_comb begin
    line = lbuf_q;
    line[cnt_q] = mem_data_i;
  end
  for (genvar g = 0; g < 2; g++) begin : g_way
    icache_way #(.SET_BITS(SET_BITS), .WORD_BITS(WORD_BITS), .TAG_BITS(TAG_BITS)) u_way (
      .clk(clk), .rst(rst),
      .rd_idx_i(ridx), .rd_tag_i(rtag), .rd_off_i(req_addr_i[2 +: WORD_BITS]),
      .hit_o(hit_w[g]), .word_o(word[g]),
      .clr_i(rdy && flush_i), .we_i(fill && victim == 1'(g)),
      .wr_idx_i(widx), .wr_tag_i(wtag), .wr_line_i(line), .wr_valid_o(wv[g])
    );
  end
  always_ff @(posedge clk)
    state_q <= rst ? S_IDLE : state_d;
  always_comb
    state_d = !rdy ? state_q
            : flush_i ? S_IDLE
            : (state_q == S_IDLE && req_i && !(|hit_w)) ? S_REFILL
            : (acc && last) ? S_IDLE
            : state_q;
  always_comb begin
    hit_o = lookup && |hit_w;
    inst_o = hit_o ? (hit_w[0] ? word[0] : word[1]) : `ZeroWord;
    busy_o = (!rst && state_q == S_REFILL) ? `Enable : `Disable;
    mem_req_o = busy_o;
    mem_addr_o = busy_o ? {base_q, cnt_q, 2'b00} : `ZeroWord;
  end
  always_comb begin
    cnt_d = !rdy ? cnt_q : flush_i ? '0 : acc ? cnt_q + 1'b1 : cnt_q;
    base_d = (lookup && !(|hit_w)) ? req_addr_i[31:LO] : base_q;
    lbuf_d = acc ? line : lbuf_q;
    lru_d = lru_q;
    if (lookup && |hit_w) lru_d[ridx] = hit_w[0] ? `Enable : `Disable;
    if (fill) lru_d[widx] = !victim;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q <= '0;
      lru_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lru_q <= lru_d;
    end
  always_ff @(posedge clk) begin
    base_q <= base_d;
    lbuf_q <= lbuf_d;
  end
endmodule
